search_ctrl: RTL and testbench

- Sequencer that owns the single port of the 256x8 pattern-search BRAM (blk_mem_gen_0, 1-cycle read latency).
- On start: loads the pattern bytes from BRAM into an internal buffer, then scans the search block with a naive sliding-window compare.
- Reports every match address through a valid/ready handshake, then signals done.
- Sits between the top-level command logic and the BRAM; it is the only driver of the BRAM address/enable.

---
 rtl/search_pkg.sv | 19 +
 rtl/search_ctrl_if.sv | 26 ++
 rtl/search_pat_buf.sv | 23 ++
 rtl/search_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_search_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/search_pkg.sv
// Shared types and defaults for the pattern-search sequencer.
package search_pkg;

  localparam int unsigned ADDR_W_DFLT  = 8;
  localparam int unsigned DATA_W_DFLT  = 8;
  localparam int unsigned MAX_PAT_DFLT = 16;
  localparam int unsigned BRAM_DEPTH   = 256;
  localparam int unsigned BRAM_LAT     = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_SCAN,
    S_HOLD,
    S_FINISH
  } state_e;

endpackage

// File: rtl/search_ctrl_if.sv
// BRAM read port and match handshake between search_ctrl and its neighbours.
interface search_ctrl_if
  import search_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
);

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic              match_valid;
  logic              match_ready;
  logic [ADDR_W-1:0] match_addr;

  modport master (
    output bram_en, bram_addr, match_valid, match_addr,
    input  bram_dout, match_ready
  );

  modport slave (
    input  bram_en, bram_addr, match_valid, match_addr,
    output bram_dout, match_ready
  );

endinterface

// File: rtl/search_pat_buf.sv
// Pattern buffer: MAX_PAT x DATA_W registers, one write port, combinational read.
module search_pat_buf #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_PAT = 16,
  parameter int unsigned IDX_W   = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MAX_PAT];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/search_ctrl.sv
// Naive sliding-window pattern search over a 1-cycle-latency BRAM.
// Define SEARCH_FIRST_MATCH_EN to stop after the first accepted match.
module search_ctrl
  import search_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DFLT,
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned MAX_PAT = MAX_PAT_DFLT
) (
  input  logic                CLK100MHZ,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   pat_base,
  input  logic [ADDR_W-1:0]   pat_len,
  input  logic [ADDR_W-1:0]   blk_base,
  input  logic [ADDR_W-1:0]   blk_len,
  search_ctrl_if.master       bus,
  output logic                busy,
  output logic [ADDR_W-1:0]   match_count,
  output logic                done,
  output logic                error
);

  localparam int unsigned IDX_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

`ifdef SEARCH_FIRST_MATCH_EN
  localparam bit FIRST_ONLY = 1'b1;
`else
  localparam bit FIRST_ONLY = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pat_base_q, pat_base_d;
  logic [ADDR_W-1:0] pat_len_q, pat_len_d;
  logic [ADDR_W-1:0] blk_base_q, blk_base_d;
  logic [ADDR_W-1:0] blk_len_q, blk_len_d;
  logic [ADDR_W-1:0] cand_q, cand_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] match_addr_q, match_addr_d;
  logic [ADDR_W-1:0] match_count_q, match_count_d;
  logic              error_q, error_d;

  logic [ADDR_W:0]   blk_end;
  logic              illegal;
  logic [ADDR_W-1:0] last_cand;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;

  search_pat_buf #(
    .DATA_W  (DATA_W),
    .MAX_PAT (MAX_PAT),
    .IDX_W   (IDX_W)
  ) u_pat_buf (
    .clk   (CLK100MHZ),
    .we    (buf_we),
    .waddr (rd_idx_q),
    .wdata (bus.bram_dout),
    .raddr (rd_idx_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    blk_end   = {1'b0, blk_base_q} + {1'b0, blk_len_q};
    illegal   = (pat_len_q == '0) || (pat_len_q > ADDR_W'(MAX_PAT)) ||
                (pat_len_q > blk_len_q) || (blk_end > (ADDR_W+1)'(BRAM_DEPTH));
    last_cand = blk_base_q + blk_len_q - pat_len_q;
  end

  always_comb begin
    state_d       = state_q;
    pat_base_d    = pat_base_q;
    pat_len_d     = pat_len_q;
    blk_base_d    = blk_base_q;
    blk_len_d     = blk_len_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    rd_pend_d     = 1'b0;
    rd_idx_d      = rd_idx_q;
    match_addr_d  = match_addr_q;
    match_count_d = match_count_q;
    error_d       = error_q;
    buf_we        = 1'b0;
    bram_en       = 1'b0;
    bram_addr     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_base_d    = pat_base;
          pat_len_d     = pat_len;
          blk_base_d    = blk_base;
          blk_len_d     = blk_len;
          match_count_d = '0;
          error_d       = 1'b0;
          cnt_d         = '0;
          state_d       = S_CHECK;
        end
      end

      S_CHECK: begin
        cnt_d = '0;
        if (illegal) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        buf_we = rd_pend_q;
        cnt_d  = cnt_q + 1'b1;
        if (ADDR_W'(cnt_q) < pat_len_q) begin
          bram_en   = 1'b1;
          bram_addr = pat_base_q + ADDR_W'(cnt_q);
          rd_pend_d = 1'b1;
          rd_idx_d  = cnt_q[IDX_W-1:0];
        end
        // Wait out the read latency of the final pattern byte before scanning.
        if (ADDR_W'(cnt_q) == pat_len_q + ADDR_W'(BRAM_LAT - 1)) begin
          cand_d  = blk_base_q;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (ADDR_W'(cnt_q) < pat_len_q) begin
          bram_en   = 1'b1;
          bram_addr = cand_q + ADDR_W'(cnt_q);
          rd_pend_d = 1'b1;
          rd_idx_d  = cnt_q[IDX_W-1:0];
          cnt_d     = cnt_q + 1'b1;
        end
        // The compare resolves a read from the previous cycle; a mismatch
        // drops the read issued this cycle and restarts at the next window.
        if (rd_pend_q) begin
          if (bus.bram_dout != buf_rdata) begin
            rd_pend_d = 1'b0;
            cnt_d     = '0;
            if (cand_q == last_cand) state_d = S_FINISH;
            else                     cand_d  = cand_q + 1'b1;
          end else if (ADDR_W'(rd_idx_q) == pat_len_q - 1'b1) begin
            rd_pend_d    = 1'b0;
            match_addr_d = cand_q;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (bus.match_ready) begin
          if (match_count_q != '1) match_count_d = match_count_q + 1'b1;
          cnt_d = '0;
          if (FIRST_ONLY || cand_q == last_cand) begin
            state_d = S_FINISH;
          end else begin
            cand_d  = cand_q + 1'b1;
            state_d = S_SCAN;
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pat_base_q    <= '0;
      pat_len_q     <= '0;
      blk_base_q    <= '0;
      blk_len_q     <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      rd_pend_q     <= 1'b0;
      rd_idx_q      <= '0;
      match_addr_q  <= '0;
      match_count_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_base_q    <= pat_base_d;
      pat_len_q     <= pat_len_d;
      blk_base_q    <= blk_base_d;
      blk_len_q     <= blk_len_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rd_pend_q     <= rd_pend_d;
      rd_idx_q      <= rd_idx_d;
      match_addr_q  <= match_addr_d;
      match_count_q <= match_count_d;
      error_q       <= error_d;
    end
  end

  assign bus.bram_en     = bram_en;
  assign bus.bram_addr   = bram_addr;
  assign bus.match_valid = (state_q == S_HOLD);
  assign bus.match_addr  = match_addr_q;
  assign busy            = (state_q == S_CHECK) || (state_q == S_LOAD) ||
                           (state_q == S_SCAN)  || (state_q == S_HOLD);
  assign done            = (state_q == S_FINISH);
  assign error           = error_q;
  assign match_count     = match_count_q;

endmodule

// File: tb/tb_search_ctrl.sv
// Directed bench for search_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_search_ctrl;
  import search_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pat_base = '0, pat_len = '0, blk_base = '0, blk_len = '0;
  logic       busy, done, error;
  logic [7:0] match_count;

  search_ctrl_if #(.ADDR_W(8), .DATA_W(8)) sif ();

  search_ctrl #(.ADDR_W(8), .DATA_W(8), .MAX_PAT(16)) dut (
    .CLK100MHZ   (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pat_base    (pat_base),
    .pat_len     (pat_len),
    .blk_base    (blk_base),
    .blk_len     (blk_len),
    .bus         (sif),
    .busy        (busy),
    .match_count (match_count),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (sif.bram_en) sif.bram_dout <= mem[sif.bram_addr];

  int checks = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_cyc;
  bit         en_seen;
  bit         hold_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one search; hold>0 stalls match_ready on the first match for that many cycles.
  task automatic run(input logic [7:0] pb, input logic [7:0] pl, input logic [7:0] bb,
                     input logic [7:0] bl, input int hold);
    int         n;
    int         hold_left;
    logic [7:0] held;
    got_q.delete();
    done_cyc  = -1;
    en_seen   = 1'b0;
    hold_ok   = 1'b1;
    hold_left = hold;
    held      = '0;
    @(negedge clk);
    pat_base = pb; pat_len = pl; blk_base = bb; blk_len = bl;
    start = 1'b1;
    sif.match_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 400) begin
      if (sif.bram_en) en_seen = 1'b1;
      if (done) begin
        done_cyc = n;
        break;
      end
      if (sif.match_valid) begin
        if (hold_left > 0) begin
          if (hold_left == hold) held = sif.match_addr;
          if (sif.match_addr !== held || sif.bram_en !== 1'b0) hold_ok = 1'b0;
          hold_left--;
          sif.match_ready = 1'b0;
        end else begin
          sif.match_ready = 1'b1;
          got_q.push_back(sif.match_addr);
        end
      end
      @(negedge clk);
      n++;
    end
    sif.match_ready = 1'b1;
    check("done_seen", 32'(done_cyc >= 0), 1);
  endtask

  task automatic check_matches(input string tag);
    check({tag, "_num"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_addr"}, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
  endtask

  task automatic check_error_run(input string tag);
    check({tag, "_err"}, error, 1);
    check({tag, "_done_cyc"}, done_cyc, 2);
    check({tag, "_no_en"}, en_seen, 0);
    check({tag, "_cnt"}, match_count, 0);
    check({tag, "_nmatch"}, got_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = "A"; mem[1] = "B"; mem[2] = "A";
    mem[4] = "A"; mem[5] = "A";
    mem[16] = "X"; mem[17] = "A"; mem[18] = "B"; mem[19] = "A";
    mem[20] = "X"; mem[21] = "A"; mem[22] = "B"; mem[23] = "A";
    for (int i = 32; i < 36; i++) mem[i] = "A";
    mem[252] = "X"; mem[253] = "X"; mem[254] = "A"; mem[255] = "B";
    sif.match_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, error, sif.bram_en, sif.match_valid,
                         match_count, sif.match_addr, sif.bram_addr}, 0);
    reset_n = 1'b1;

    // "ABA" in "XABAXABA"
    run(8'd0, 8'd3, 8'd16, 8'd8, 0);
`ifdef SEARCH_FIRST_MATCH_EN
    exp_q = '{8'd17};
`else
    exp_q = '{8'd17, 8'd21};
`endif
    check_matches("s1");
    check("s1_cnt", match_count, exp_q.size());
    check("s1_err", error, 0);
    @(negedge clk);
    check("s1_done_pulse", done, 0);
    check("s1_idle_busy", busy, 0);

    // Overlapping "AA" in "AAAA"
    run(8'd4, 8'd2, 8'd32, 8'd4, 0);
`ifdef SEARCH_FIRST_MATCH_EN
    exp_q = '{8'd32};
`else
    exp_q = '{8'd32, 8'd33, 8'd34};
`endif
    check_matches("s2");
    check("s2_cnt", match_count, exp_q.size());

    // Backpressure on the first match
    run(8'd0, 8'd3, 8'd16, 8'd8, 10);
`ifdef SEARCH_FIRST_MATCH_EN
    exp_q = '{8'd17};
`else
    exp_q = '{8'd17, 8'd21};
`endif
    check("s3_hold_stable", hold_ok, 1);
    check_matches("s3");

    run(8'd0, 8'd0, 8'd16, 8'd8, 0);
    check_error_run("e_len0");
    @(negedge clk);
    check("e_len0_err_held", error, 1);
    run(8'd0, 8'd5, 8'd16, 8'd4, 0);
    check_error_run("e_pat_gt_blk");
    run(8'd0, 8'd3, 8'd250, 8'd10, 0);
    check_error_run("e_blk_wrap");
    run(8'd0, 8'd17, 8'd16, 8'd20, 0);
    check_error_run("e_pat_gt_max");

    // Block ending exactly at the top of memory
    run(8'd0, 8'd2, 8'd252, 8'd4, 0);
    exp_q = '{8'd254};
    check_matches("s_top");
    check("s_top_err", error, 0);

    // pat_len == blk_len: single candidate
    run(8'd0, 8'd3, 8'd17, 8'd3, 0);
    exp_q = '{8'd17};
    check_matches("s_one");

    // No match at all
    run(8'd0, 8'd3, 8'd32, 8'd4, 0);
    exp_q.delete();
    check_matches("s_none");
    check("s_none_cnt", match_count, 0);
    check("s_none_err", error, 0);

    // Reset in the middle of the scan
    @(negedge clk);
    pat_base = 8'd0; pat_len = 8'd3; blk_base = 8'd16; blk_len = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {busy, done, error, sif.bram_en, sif.match_valid,
                           match_count, sif.match_addr, sif.bram_addr}, 0);
    reset_n = 1'b1;
    run(8'd0, 8'd3, 8'd16, 8'd8, 0);
`ifdef SEARCH_FIRST_MATCH_EN
    exp_q = '{8'd17};
`else
    exp_q = '{8'd17, 8'd21};
`endif
    check_matches("rst_rerun");
    check("rst_rerun_cnt", match_count, exp_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
